// File: rtl/boruss_trace_buffer_pkg.sv
// Boruss trace capture: shared encodings and record layout.
// Imported by the trace buffer top and its FIFO.
package boruss_trace_buffer_pkg;

  typedef enum logic [2:0] {
    CPU_FETCH     = 3'b000,
    CPU_DECODE    = 3'b001,
    CPU_EXECUTE   = 3'b010,
    CPU_WRITEBACK = 3'b011,
    CPU_FETCH_IMM = 3'b100,
    CPU_HALT      = 3'b101
  } cpu_state_e;

  typedef enum logic [1:0] {
    MODE_ALL  = 2'b00,
    MODE_TRIG = 2'b01,
    MODE_CHG  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    TR_IDLE    = 2'd0,
    TR_ARMED   = 2'd1,
    TR_CAPTURE = 2'd2,
    TR_DONE    = 2'd3
  } trace_state_e;

  // Record = {ts, state, pc, chg_mask, reg_bus}, reg_bus in the LSBs.
  function automatic int rec_chg_lsb(int data_w, int nregs);
    return nregs * data_w;
  endfunction

  function automatic int rec_pc_lsb(int data_w, int nregs);
    return rec_chg_lsb(data_w, nregs) + nregs;
  endfunction

  function automatic int rec_st_lsb(int data_w, int nregs);
    return rec_pc_lsb(data_w, nregs) + data_w;
  endfunction

  function automatic int rec_ts_lsb(int data_w, int nregs);
    return rec_st_lsb(data_w, nregs) + 3;
  endfunction

endpackage

// File: rtl/boruss_trace_fifo.sv
// Show-ahead FIFO with registered head, flush and
// optional overwrite-oldest when full.
module boruss_trace_fifo
  import boruss_trace_buffer_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       overwrite_en_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  data_q, data_d;
  logic          do_pop, do_wr, ovw, wr_en;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CW'(DEPTH));
    do_pop  = pop_i && !empty_o;
    do_wr   = push_i &&
              (!full_o || do_pop || overwrite_en_i);
    ovw     = do_wr && full_o && !do_pop;
    wr_en   = do_wr && !flush_i;
    wptr_d  = wptr_q + AW'(do_wr);
    rptr_d  = rptr_q + AW'(do_pop || ovw);
    count_d = count_q;
    unique case ({do_wr && !ovw, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
    // Head stays put when empty so rdata holds its last value.
    data_d = data_q;
    if (count_d != '0) begin
      if (wr_en && (wptr_q == rptr_d))
        data_d = wdata_i;
      else
        data_d = mem[rptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign rdata_o = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/boruss_trace_buffer.sv
// Boruss on-chip trace capture: trigger FSM, qualifier,
// change snapshot and timestamp in front of a trace FIFO.
module boruss_trace_buffer
  import boruss_trace_buffer_pkg::*;
#(
  parameter int         DATA_W     = 8,
  parameter int         NUM_REGS   = 4,
  parameter int         DEPTH      = 16,
  parameter int         TS_W       = 8,
  parameter logic [2:0] TRIG_STATE = CPU_WRITEBACK,
  parameter logic [2:0] HALT_STATE = CPU_HALT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_en,
  input  logic [2:0]                   cpu_state,
  input  logic [DATA_W-1:0]            pc,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_bus,
  input  logic                         arm,
  input  logic                         disarm,
  input  logic [1:0]                   mode,
  input  logic                         stop_on_full,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [TS_W+3+DATA_W+NUM_REGS+NUM_REGS*DATA_W-1:0] rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [1:0]                   trace_state
);

  localparam int RW = TS_W + 3 + DATA_W + NUM_REGS
                    + NUM_REGS * DATA_W;
  localparam int BW = NUM_REGS * DATA_W;

  trace_state_e  state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [BW-1:0] snap_q, snap_d;
  logic          ovf_q, ovf_d;
  logic [NUM_REGS-1:0] chg;
  logic          is_trig, is_halt, qual;
  logic          push_req, push, flush, pop;
  logic          fifo_full, fifo_empty;
  logic [RW-1:0] rec;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      chg[i] = reg_bus[i*DATA_W +: DATA_W]
            != snap_q[i*DATA_W +: DATA_W];
  end

  assign is_trig = (cpu_state == TRIG_STATE);
  assign is_halt = (cpu_state == HALT_STATE);
  assign rec     = {ts_q, cpu_state, pc, chg, reg_bus};
  assign pop     = rd_valid && rd_ready;

  always_comb begin
    unique case (mode_e'(mode))
      MODE_TRIG: qual = is_trig;
      MODE_CHG:  qual = |chg;
      default:   qual = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ts_d     = ts_q;
    snap_d   = snap_q;
    ovf_d    = ovf_q;
    push_req = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    if (disarm) begin
      state_d = TR_IDLE;
    end else if (arm) begin
      state_d = TR_ARMED;
      ts_d    = '0;
      snap_d  = reg_bus;
      ovf_d   = 1'b0;
      flush   = 1'b1;
    end else if (sample_en && state_q != TR_IDLE) begin
      ts_d   = ts_q + TS_W'(1);
      snap_d = reg_bus;
      unique case (state_q)
        TR_ARMED: begin
          if (is_trig) begin
            push_req = 1'b1;
            state_d  = TR_CAPTURE;
          end
        end
        TR_CAPTURE: begin
          push_req = qual;
          if (is_halt) state_d = TR_DONE;
        end
        default: ;
      endcase
      push = push_req;
      // A push into a full buffer with no pop loses a record.
      if (push_req && fifo_full && !pop) begin
        ovf_d = 1'b1;
        if (stop_on_full) begin
          push    = 1'b0;
          state_d = TR_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TR_IDLE;
      ts_q    <= '0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
    end
  end

  boruss_trace_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (flush),
    .push_i         (push),
    .pop_i          (pop),
    .overwrite_en_i (!stop_on_full),
    .wdata_i        (rec),
    .rdata_o        (rd_data),
    .count_o        (count),
    .full_o         (fifo_full),
    .empty_o        (fifo_empty)
  );

  assign rd_valid    = !fifo_empty;
  assign overflow    = ovf_q;
  assign trace_state = state_q;

endmodule

// File: tb/tb_boruss_trace_buffer.sv
// Directed bench for boruss_trace_buffer with
// hand-computed record expectations.
module tb_boruss_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_en;
  logic [2:0]  cpu_state;
  logic [7:0]  pc;
  logic [31:0] reg_bus;
  logic        arm, disarm;
  logic [1:0]  mode;
  logic        stop_on_full;
  logic        rd_valid, rd_ready;
  logic [54:0] rd_data;
  logic [4:0]  count;
  logic        overflow;
  logic [1:0]  trace_state;

  int checks   = 0;
  int failures = 0;

  wire [7:0]  f_ts   = rd_data[54:47];
  wire [2:0]  f_st   = rd_data[46:44];
  wire [7:0]  f_pc   = rd_data[43:36];
  wire [3:0]  f_chg  = rd_data[35:32];
  wire [31:0] f_regs = rd_data[31:0];

  always #5 clk = ~clk;

  boruss_trace_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_en    (sample_en),
    .cpu_state    (cpu_state),
    .pc           (pc),
    .reg_bus      (reg_bus),
    .arm          (arm),
    .disarm       (disarm),
    .mode         (mode),
    .stop_on_full (stop_on_full),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .count        (count),
    .overflow     (overflow),
    .trace_state  (trace_state)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic samp(input logic [2:0] st,
                      input logic [7:0] p,
                      input logic [31:0] r);
    cpu_state = st;
    pc        = p;
    reg_bus   = r;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic do_arm();
    reg_bus = 32'h0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pop1();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    arm   = 1'b1;
    tick();
    tick();
    arm = 1'b0;
    checks++;
    if (trace_state !== 2'd0) begin
      failures++;
      $display("FAIL rst_state got=%0d exp=0", trace_state);
    end
    checks++;
    if (count !== 5'd0) begin
      failures++;
      $display("FAIL rst_count got=%0d exp=0", count);
    end
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid got=%b exp=0", rd_valid);
    end
    checks++;
    if (rd_data !== 55'h0) begin
      failures++;
      $display("FAIL rst_data got=%h exp=0", rd_data);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_ovf got=%b exp=0", overflow);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_trigger();
    mode = 2'b00;
    stop_on_full = 1'b0;
    do_arm();
    samp(3'b000, 8'h00, 32'h0);
    samp(3'b001, 8'h00, 32'h0);
    samp(3'b010, 8'h01, 32'h0);
    checks++;
    if (count !== 5'd0 || trace_state !== 2'd1) begin
      failures++;
      $display("FAIL pre_trig count=%0d st=%0d exp 0/1",
               count, trace_state);
    end
    samp(3'b011, 8'h02, 32'h0000_0001);
    checks++;
    if (count !== 5'd1 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL trig_count count=%0d v=%b exp 1/1",
               count, rd_valid);
    end
    checks++;
    if (f_ts !== 8'd3 || f_st !== 3'b011 ||
        f_pc !== 8'h02 || f_chg !== 4'b0001 ||
        f_regs !== 32'h1) begin
      failures++;
      $display("FAIL trig_rec got=%h exp ts=3 st=3 pc=2 chg=1",
               rd_data);
    end
    checks++;
    if (trace_state !== 2'd2) begin
      failures++;
      $display("FAIL trig_state got=%0d exp=2", trace_state);
    end
  endtask

  task automatic test_overwrite();
    mode = 2'b01;
    stop_on_full = 1'b0;
    rd_ready = 1'b0;
    do_arm();
    samp(3'b010, 8'h00, 32'h0);
    samp(3'b011, 8'h10, 32'h0);
    for (int i = 0; i < 20; i++)
      samp(3'b011, 8'h10 + 8'(i), 32'h0);
    checks++;
    if (count !== 5'd16) begin
      failures++;
      $display("FAIL ovw_count got=%0d exp=16", count);
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovw_ovf got=%b exp=1", overflow);
    end
    checks++;
    if (f_ts !== 8'd6) begin
      failures++;
      $display("FAIL ovw_first_ts got=%0d exp=6", f_ts);
    end
    pop1();
    checks++;
    if (f_ts !== 8'd7 || count !== 5'd15) begin
      failures++;
      $display("FAIL ovw_pop ts=%0d count=%0d exp 7/15",
               f_ts, count);
    end
  endtask

  task automatic test_stop_full();
    mode = 2'b00;
    stop_on_full = 1'b1;
    rd_ready = 1'b0;
    do_arm();
    samp(3'b011, 8'h00, 32'h0);
    for (int i = 1; i < 16; i++)
      samp(3'b000, 8'(i), 32'h0);
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full16 count=%0d ovf=%b exp 16/0",
               count, overflow);
    end
    samp(3'b000, 8'h40, 32'h0);
    checks++;
    if (count !== 5'd16 || overflow !== 1'b1 ||
        trace_state !== 2'd3) begin
      failures++;
      $display("FAIL full17 count=%0d ovf=%b st=%0d exp 16/1/3",
               count, overflow, trace_state);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || f_ts !== 8'(i) ||
          f_pc !== 8'(i)) begin
        failures++;
        $display("FAIL drain_%0d v=%b ts=%0d pc=%0d exp ts=pc=%0d",
                 i, rd_valid, f_ts, f_pc, i);
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || count !== 5'd0) begin
      failures++;
      $display("FAIL drain_end v=%b count=%0d exp 0/0",
               rd_valid, count);
    end
    checks++;
    if (f_ts !== 8'd15) begin
      failures++;
      $display("FAIL empty_hold ts=%0d exp=15", f_ts);
    end
  endtask

  task automatic test_change();
    mode = 2'b10;
    stop_on_full = 1'b0;
    rd_ready = 1'b0;
    do_arm();
    samp(3'b011, 8'h00, 32'h0);
    samp(3'b000, 8'h01, 32'h0);
    samp(3'b001, 8'h02, 32'h0000_0500);
    samp(3'b010, 8'h03, 32'h0000_0500);
    samp(3'b000, 8'h04, 32'h0000_0500);
    checks++;
    if (count !== 5'd2) begin
      failures++;
      $display("FAIL chg_count got=%0d exp=2", count);
    end
    checks++;
    if (f_chg !== 4'b0000 || f_st !== 3'b011) begin
      failures++;
      $display("FAIL chg_trig chg=%b st=%0d exp 0000/3",
               f_chg, f_st);
    end
    pop1();
    checks++;
    if (f_chg !== 4'b0010 || f_regs[15:8] !== 8'h05 ||
        f_st !== 3'b001 || f_ts !== 8'd2) begin
      failures++;
      $display("FAIL chg_rec chg=%b r1=%h st=%0d ts=%0d exp 0010/05/1/2",
               f_chg, f_regs[15:8], f_st, f_ts);
    end
    pop1();
  endtask

  task automatic test_halt();
    mode = 2'b00;
    stop_on_full = 1'b0;
    do_arm();
    samp(3'b011, 8'h00, 32'h0);
    samp(3'b010, 8'h01, 32'h0);
    samp(3'b101, 8'h02, 32'h0);
    checks++;
    if (trace_state !== 2'd3 || count !== 5'd3) begin
      failures++;
      $display("FAIL halt st=%0d count=%0d exp 3/3",
               trace_state, count);
    end
    samp(3'b000, 8'h03, 32'h0);
    checks++;
    if (count !== 5'd3) begin
      failures++;
      $display("FAIL done_ignore count=%0d exp=3", count);
    end
    pop1();
    reset = 1'b1;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || count !== 5'd0 ||
        trace_state !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset v=%b count=%0d st=%0d exp 0/0/0",
               rd_valid, count, trace_state);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_arm_disarm();
    mode = 2'b00;
    stop_on_full = 1'b0;
    do_arm();
    samp(3'b011, 8'h11, 32'h0);
    samp(3'b010, 8'h22, 32'h0);
    arm = 1'b1;
    disarm = 1'b1;
    tick();
    arm = 1'b0;
    disarm = 1'b0;
    checks++;
    if (trace_state !== 2'd0 || count !== 5'd2 ||
        f_pc !== 8'h11) begin
      failures++;
      $display("FAIL arm_disarm st=%0d count=%0d pc=%h exp 0/2/11",
               trace_state, count, f_pc);
    end
    samp(3'b011, 8'h33, 32'h0);
    checks++;
    if (count !== 5'd2) begin
      failures++;
      $display("FAIL idle_ignore count=%0d exp=2", count);
    end
    pop1();
    checks++;
    if (f_pc !== 8'h22 || count !== 5'd1) begin
      failures++;
      $display("FAIL idle_read pc=%h count=%0d exp 22/1",
               f_pc, count);
    end
  endtask

  initial begin
    reset = 1'b1;
    sample_en = 1'b0;
    cpu_state = 3'b000;
    pc = 8'h0;
    reg_bus = 32'h0;
    arm = 1'b0;
    disarm = 1'b0;
    mode = 2'b00;
    stop_on_full = 1'b0;
    rd_ready = 1'b0;
    tick();
    test_reset();
    test_trigger();
    test_overwrite();
    test_stop_full();
    test_change();
    test_halt();
    test_arm_disarm();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
